clk_tick_scheduler: RTL
=======================

// Module: clk_tick_scheduler
// PURPOSE
//  Programmable clock-enable scheduler that sequences the Reed-Solomon datapath.
//  Emits single-cycle tick_en strobes every div_q cycles of clk_in; no derived clock is produced.
//  Modes: free-run, single-step, N-tick burst. The divisor is loaded at runtime through a
//  valid/ready config port. Sits between the top-level control/UI and the RS encoder/decoder enables.
// PARAMETERS
//  CNT_W        32        width of divisor register and tick counter
//  DEFAULT_DIV  100_000   divisor value after reset
//  BURST_W      16        width of burst_len and ticks_left
// PORTS
//  clk_in      in   1        single clock; all logic on rising edge
//  reset       in   1        synchronous, active-high
//  cfg_valid   in   1        divisor write request
//  cfg_div     in   CNT_W    new divisor; values 0 and 1 are both stored as 1
//  cfg_ready   out  1        high only in IDLE
//  cmd_valid   in   1        command request
//  cmd         in   2        00 STOP, 01 RUN, 10 STEP, 11 BURST
//  burst_len   in   BURST_W  tick count for BURST; sampled on accept
//  cmd_ready   out  1        (state==IDLE) | (cmd==STOP)
//  tick_en     out  1        registered one-cycle enable strobe
//  done        out  1        registered one-cycle pulse on natural STEP/BURST completion
//  busy        out  1        state != IDLE
//  state_o     out  2        IDLE=0, RUN=1, STEP=2, BURST=3
//  ticks_left  out  BURST_W  remaining BURST ticks; 0 outside BURST
// BEHAVIOUR
//  Reset values at the edge where reset=1:
//   state=IDLE, div_q=DEFAULT_DIV, counter=0, tick_en=0, done=0, ticks_left=0.
//   Reset mid-operation aborts immediately; no done pulse is issued.
//  Config: accepted at an edge with cfg_valid & cfg_ready; div_q=max(cfg_div,1) from the next cycle.
//  Command accept: edge E0 with cmd_valid & cmd_ready. On a non-STOP accept, counter<=0.
//  Counter, in any active state, at each edge:
//   if counter==div_q-1: counter<=0, tick_en<=1.
//   otherwise: counter<=counter+1, tick_en<=0.
//  Tick timing: first tick_en is high in the cycle after edge E0+div_q, then every div_q cycles.
//   div_q=1 gives tick_en high every cycle from E1.
//  Transitions:
//   IDLE -> RUN/STEP/BURST on accept. STOP accepted in IDLE is a no-op.
//   RUN: ticks until STOP.
//   STEP: on the tick edge -> IDLE; done=1 in the same cycle as tick_en.
//   BURST: ticks_left<=burst_len on accept; each tick decrements it.
//    Tick that makes it 0 -> IDLE, with done and tick_en together.
//    burst_len=0 -> at E1 state=IDLE, done=1, no tick.
//  STOP in an active state: -> IDLE at the accept edge; counter<=0, ticks_left<=0, no done.
//   If that edge coincides with counter==div_q-1, the tick is suppressed (tick_en=0).
//  RUN/STEP/BURST while busy: cmd_ready=0; the command is held off and not dropped.
//  cfg while busy: cfg_ready=0; div_q is never changed mid-sequence.
//  No combinational path from any input to tick_en or done.
//  Counter compare uses CNT_W bits; div_q-1 never underflows because div_q>=1.
// STRUCTURE
//  Package rs_clk_pkg: CMD_STOP/RUN/STEP/BURST, ST_IDLE/RUN/STEP/BURST encodings.
//  Sub-module tick_counter #(CNT_W): modulo-div counter with clear/enable inputs and a
//   wrap pulse. The scheduler FSM wraps it and owns the burst counter and the handshakes.
// TESTING
//  1 reset, no cmd -> tick_en=0, busy=0, cfg_ready=1, state_o=0 for 20 cycles.
//  2 cfg_div=4, RUN at E0
//     -> tick_en high after E4, E8, E12, ...; STOP at E10 -> no tick at E12, state_o=0.
//  3 cfg_div=3, STEP at E0 -> single tick_en+done after E3; busy=0 from E3; no further ticks.
//  4 cfg_div=2, BURST burst_len=5
//     -> ticks after E2, E4, E6, E8, E10; done with the 5th tick; ticks_left 5..0.
//  5 cfg_div=0 -> stored as 1, RUN -> tick_en high every cycle from E1;
//     cfg_valid while busy -> cfg_ready=0, div unchanged.
//  6 BURST burst_len=0 -> done after E1, no tick;
//     reset asserted mid-RUN -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/clk_tick_scheduler_pkg.sv
// Shared encodings for the clock-enable scheduler: command codes and FSM states.
package rs_clk_pkg;

  typedef enum logic [1:0] {
    CMD_STOP  = 2'd0,
    CMD_RUN   = 2'd1,
    CMD_STEP  = 2'd2,
    CMD_BURST = 2'd3
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STEP  = 2'd2,
    ST_BURST = 2'd3
  } state_e;

  // A command that starts a sequence (anything other than STOP).
  function automatic logic is_start_cmd(input logic [1:0] code);
    return (code != CMD_STOP);
  endfunction

endpackage

// File: rtl/clk_tick_scheduler_tick_counter.sv
// Modulo-div counter. wrap is high in the cycle where the counter sits at div-1
// while enabled; on that edge the counter returns to zero.
module tick_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] div,
  output logic             wrap
);

  logic [CNT_W-1:0] count;

  // div is never below 1, so div-1 cannot underflow.
  assign wrap = enable & (count == (div - CNT_W'(1)));

  // Counter register: clear has priority over counting, idle holds.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= {CNT_W{1'b0}};
    end else if (clear) begin
      count <= {CNT_W{1'b0}};
    end else if (enable) begin
      count <= wrap ? {CNT_W{1'b0}} : (count + CNT_W'(1));
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/clk_tick_scheduler.sv
// Clock-enable scheduler for the Reed-Solomon datapath. Produces single-cycle
// tick_en strobes every div_q cycles in free-run, single-step or N-tick burst mode.
module clk_tick_scheduler
  import rs_clk_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int DEFAULT_DIV = 100_000,
  parameter int BURST_W     = 16
) (
  input  logic               clk_in,
  input  logic               reset,
  input  logic               cfg_valid,
  input  logic [CNT_W-1:0]   cfg_div,
  output logic               cfg_ready,
  input  logic               cmd_valid,
  input  logic [1:0]         cmd,
  input  logic [BURST_W-1:0] burst_len,
  output logic               cmd_ready,
  output logic               tick_en,
  output logic               done,
  output logic               busy,
  output logic [1:0]         state_o,
  output logic [BURST_W-1:0] ticks_left
);

  state_e             state;
  state_e             state_n;
  logic [CNT_W-1:0]   div_q;
  logic [CNT_W-1:0]   div_n;
  logic [BURST_W-1:0] left_n;
  logic               tick_n;
  logic               done_n;
  logic               cnt_clear;
  logic               cnt_enable;
  logic               cnt_wrap;
  logic               cmd_accept;

  // Handshakes depend only on the state register (and cmd for STOP pass-through).
  assign cfg_ready  = (state == ST_IDLE);
  assign cmd_ready  = (state == ST_IDLE) | (cmd == CMD_STOP);
  assign cmd_accept = cmd_valid & cmd_ready;
  assign busy       = (state != ST_IDLE);
  assign state_o    = state;

  tick_counter #(
    .CNT_W (CNT_W)
  ) u_tick_counter (
    .clk    (clk_in),
    .reset  (reset),
    .clear  (cnt_clear),
    .enable (cnt_enable),
    .div    (div_q),
    .wrap   (cnt_wrap)
  );

  // Next-state, burst bookkeeping and strobe generation.
  always_comb begin
    state_n    = state;
    div_n      = div_q;
    left_n     = ticks_left;
    tick_n     = 1'b0;
    done_n     = 1'b0;
    cnt_clear  = 1'b0;
    cnt_enable = 1'b0;

    case (state)
      ST_IDLE: begin
        if (cfg_valid) begin
          div_n = (cfg_div == {CNT_W{1'b0}}) ? CNT_W'(1) : cfg_div;
        end else begin
          div_n = div_q;
        end
        if (cmd_accept && is_start_cmd(cmd)) begin
          cnt_clear = 1'b1;
          case (cmd)
            CMD_RUN:   state_n = ST_RUN;
            CMD_STEP:  state_n = ST_STEP;
            CMD_BURST: begin
              state_n = ST_BURST;
              left_n  = burst_len;
            end
            default:   state_n = ST_IDLE;
          endcase
        end else begin
          state_n = ST_IDLE;
        end
      end

      ST_RUN: begin
        if (cmd_accept) begin
          state_n   = ST_IDLE;
          cnt_clear = 1'b1;
        end else begin
          cnt_enable = 1'b1;
          tick_n     = cnt_wrap;
        end
      end

      ST_STEP: begin
        if (cmd_accept) begin
          state_n   = ST_IDLE;
          cnt_clear = 1'b1;
        end else begin
          cnt_enable = 1'b1;
          if (cnt_wrap) begin
            tick_n  = 1'b1;
            done_n  = 1'b1;
            state_n = ST_IDLE;
          end else begin
            state_n = ST_STEP;
          end
        end
      end

      ST_BURST: begin
        if (cmd_accept) begin
          state_n   = ST_IDLE;
          cnt_clear = 1'b1;
          left_n    = {BURST_W{1'b0}};
        end else if (ticks_left == {BURST_W{1'b0}}) begin
          // Zero-length burst completes immediately without a tick.
          state_n = ST_IDLE;
          done_n  = 1'b1;
        end else begin
          cnt_enable = 1'b1;
          if (cnt_wrap) begin
            tick_n = 1'b1;
            left_n = ticks_left - BURST_W'(1);
            if (ticks_left == BURST_W'(1)) begin
              done_n  = 1'b1;
              state_n = ST_IDLE;
            end else begin
              state_n = ST_BURST;
            end
          end else begin
            state_n = ST_BURST;
          end
        end
      end

      default: begin
        state_n   = ST_IDLE;
        left_n    = {BURST_W{1'b0}};
        cnt_clear = 1'b1;
      end
    endcase
  end

  // State, divisor, burst count and output strobes are all registered.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state      <= ST_IDLE;
      div_q      <= CNT_W'(DEFAULT_DIV);
      ticks_left <= {BURST_W{1'b0}};
      tick_en    <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      div_q      <= div_n;
      ticks_left <= left_n;
      tick_en    <= tick_n;
      done       <= done_n;
    end
  end

endmodule
